// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: input conditioning, 1 Hz / 2 Hz tick generation, RUN/PAUSE/ADJ/CLEAR
// mode FSM, adjust-field blink phase and display digit scan.
module stopwatch_ctrl #(
  parameter int TICK_DIV    = 100000000,
  parameter int DB_CYCLES   = 1000000,
  parameter int REFRESH_DIV = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic       tick_en,
  output logic       cnt_clr,
  output logic       adj_mode,
  output logic       sel_field,
  output logic       blink,
  output logic [1:0] digit_idx,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_PAUSE = 2'b01,
    ST_ADJ   = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICK_DIV / 2 - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);

  // Synchronizer bit map: 0 = pause, 1 = clear, 2 = adjust, 3 = field select.
  logic [3:0] sync_a, sync_b;

  // NOTE: every clocked block uses non-blocking assignments so all flops sample
  // the pre-edge values of each other, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sw_sel, sw_adj, btn_clr, btn_pause};
      sync_b <= sync_a;
    end
  end

  assign sel_field = sync_b[3];

  // Button debouncers: index 0 = pause, 1 = clear.
  logic [DW-1:0] db_cnt [2];
  logic [1:0]    db_lvl;
  logic [1:0]    press;

  // NOTE: db_cnt is a two-entry register array, not a RAM, so it is reset with
  // everything else; a pending debounce must not survive rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      db_lvl <= '0;
      press  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] != db_lvl[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_cnt[i] <= '0;
            db_lvl[i] <= sync_b[i];
            press[i]  <= sync_b[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  logic pause_press, clr_press, adj_lvl;
  assign pause_press = press[0];
  assign clr_press   = press[1];
  assign adj_lvl     = sync_b[2];

  // Free-running tick divider; its phase is never disturbed by mode changes.
  logic [TW-1:0] div;
  logic          tick_1hz, tick_2hz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div <= '0;
    else     div <= (div == TICK_LAST) ? '0 : div + TW'(1);
  end

  assign tick_1hz = (div == TICK_LAST);
  assign tick_2hz = tick_1hz | (div == TICK_HALF);

  state_t st;
  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_RUN;
      tick_en  <= 1'b0;
      cnt_clr  <= 1'b0;
      adj_mode <= 1'b0;
      blink    <= 1'b1;
    end else begin
      // A clear about to happen suppresses the tick so the strobes never overlap.
      tick_en <= !clr_press && ((st == ST_RUN && tick_1hz) || (st == ST_ADJ && tick_2hz));
      cnt_clr <= clr_press;
      blink   <= (st == ST_ADJ) ? (blink ^ tick_2hz) : 1'b1;

      if (clr_press) begin
        st       <= ST_CLEAR;
        adj_mode <= 1'b0;
      end else begin
        case (st)
          ST_CLEAR: begin
            st       <= adj_lvl ? ST_ADJ : ST_RUN;
            adj_mode <= adj_lvl;
          end
          ST_RUN, ST_PAUSE: begin
            if (adj_lvl) begin
              st       <= ST_ADJ;
              adj_mode <= 1'b1;
            end else if (pause_press) begin
              st <= (st == ST_RUN) ? ST_PAUSE : ST_RUN;
            end
          end
          ST_ADJ: begin
            if (!adj_lvl) begin
              st       <= ST_RUN;
              adj_mode <= 1'b0;
            end
          end
          default: begin
            st       <= ST_RUN;
            adj_mode <= 1'b0;
          end
        endcase
      end
    end
  end

  // Digit scan runs in every state so the display never freezes.
  logic [RW-1:0] ref_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt   <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=8, DB_CYCLES=4, REFRESH_DIV=2.
// Cycle k counts rising edges since rst fell; inputs for cycle k are applied before edge k.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_RUN = 2'b00, S_PAUSE = 2'b01, S_ADJ = 2'b10, S_CLR = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_pause = 1'b0, btn_clr = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
  logic       tick_en, cnt_clr, adj_mode, sel_field, blink;
  logic [1:0] digit_idx, state;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(.TICK_DIV(8), .DB_CYCLES(4), .REFRESH_DIV(2)) dut (
    .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_clr(btn_clr),
    .sw_adj(sw_adj), .sw_sel(sw_sel), .tick_en(tick_en), .cnt_clr(cnt_clr),
    .adj_mode(adj_mode), .sel_field(sel_field), .blink(blink),
    .digit_idx(digit_idx), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: tick_en follows the state seen at the tick; a clear cancels it.
  function automatic logic m_tick(input logic [1:0] ps, input logic [1:0] es, input int k);
    return (es != S_CLR) && ((ps == S_RUN && k % 8 == 0) || (ps == S_ADJ && k % 4 == 0));
  endfunction

  function automatic logic m_blink(input logic [1:0] ps, input logic b, input int k);
    return (ps == S_ADJ) ? (b ^ (k % 4 == 0)) : 1'b1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_pause = 1'b0; btn_clr = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    btn_pause = 1'b1; btn_clr = 1'b1; sw_adj = 1'b1; sw_sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      obs = {state, tick_en, cnt_clr, adj_mode, blink, digit_idx, sel_field};
      checks++;
      if (obs !== {S_RUN, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold k=%0d got=%b exp=%b", k, obs,
                 {S_RUN, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0});
      end
    end
  endtask

  task automatic test_idle();
    logic [1:0] es, ps;
    logic       eb, et;
    int         pulses;
    apply_reset();
    ps = S_RUN; eb = 1'b1; pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      sw_sel = 1'b1;
      @(posedge clk); #1;
      es = S_RUN;
      et = m_tick(ps, es, k);
      eb = m_blink(ps, eb, k);
      if (tick_en === 1'b1) pulses++;
      checks++;
      if ({state, tick_en, cnt_clr, adj_mode, blink} !== {es, et, 1'b0, 1'b0, eb}) begin
        errors++;
        $display("FAIL idle k=%0d got=%b exp=%b", k,
                 {state, tick_en, cnt_clr, adj_mode, blink}, {es, et, 1'b0, 1'b0, eb});
      end
      checks++;
      if ({digit_idx, sel_field} !== {2'((k / 2) % 4), k >= 2}) begin
        errors++;
        $display("FAIL idle_scan k=%0d got=%b exp=%b", k, {digit_idx, sel_field},
                 {2'((k / 2) % 4), k >= 2});
      end
      ps = es;
    end
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("FAIL idle_pulses got=%0d exp=5", pulses);
    end
  endtask

  task automatic test_pause();
    logic [1:0] es, ps;
    logic       eb, et;
    apply_reset();
    ps = S_RUN; eb = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      btn_pause = (k <= 10) || (k >= 20 && k <= 29);
      @(posedge clk); #1;
      es = (k >= 7 && k <= 25) ? S_PAUSE : S_RUN;
      et = m_tick(ps, es, k);
      eb = m_blink(ps, eb, k);
      checks++;
      if ({state, tick_en, cnt_clr, adj_mode, blink} !== {es, et, 1'b0, 1'b0, eb}) begin
        errors++;
        $display("FAIL pause k=%0d got=%b exp=%b", k,
                 {state, tick_en, cnt_clr, adj_mode, blink}, {es, et, 1'b0, 1'b0, eb});
      end
      ps = es;
    end
  endtask

  task automatic test_bounce();
    logic [1:0] es, ps;
    logic       eb, et;
    apply_reset();
    ps = S_RUN; eb = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      btn_pause = (k <= 2) || (k >= 5);
      @(posedge clk); #1;
      es = (k >= 11) ? S_PAUSE : S_RUN;
      et = m_tick(ps, es, k);
      eb = m_blink(ps, eb, k);
      checks++;
      if ({state, tick_en, cnt_clr, adj_mode, blink} !== {es, et, 1'b0, 1'b0, eb}) begin
        errors++;
        $display("FAIL bounce k=%0d got=%b exp=%b", k,
                 {state, tick_en, cnt_clr, adj_mode, blink}, {es, et, 1'b0, 1'b0, eb});
      end
      ps = es;
    end
  endtask

  task automatic test_adjust();
    logic [1:0] es, ps;
    logic       eb, et;
    apply_reset();
    ps = S_RUN; eb = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      btn_pause = (k <= 6) || (k >= 14 && k <= 20);
      sw_adj    = (k >= 9 && k <= 25);
      @(posedge clk); #1;
      if (k < 7)       es = S_RUN;
      else if (k < 11) es = S_PAUSE;
      else if (k < 28) es = S_ADJ;
      else             es = S_RUN;
      et = m_tick(ps, es, k);
      eb = m_blink(ps, eb, k);
      checks++;
      if ({state, tick_en, cnt_clr, adj_mode, blink} !== {es, et, 1'b0, es == S_ADJ, eb}) begin
        errors++;
        $display("FAIL adjust k=%0d got=%b exp=%b", k,
                 {state, tick_en, cnt_clr, adj_mode, blink}, {es, et, 1'b0, es == S_ADJ, eb});
      end
      ps = es;
    end
  endtask

  task automatic test_clear();
    logic [1:0] es, ps;
    logic       eb, et;
    int         clr_pulses;
    apply_reset();
    ps = S_RUN; eb = 1'b1; clr_pulses = 0;
    for (int k = 1; k <= 36; k++) begin
      btn_pause = (k >= 2 && k <= 7);
      btn_clr   = (k >= 2 && k <= 7) || (k >= 24 && k <= 29);
      sw_adj    = (k >= 20);
      @(posedge clk); #1;
      if (k == 8 || k == 30)  es = S_CLR;
      else if (k >= 22)       es = S_ADJ;
      else                    es = S_RUN;
      et = m_tick(ps, es, k);
      eb = m_blink(ps, eb, k);
      if (cnt_clr === 1'b1) clr_pulses++;
      checks++;
      if ({state, tick_en, cnt_clr, adj_mode, blink} !==
          {es, et, es == S_CLR, es == S_ADJ, eb}) begin
        errors++;
        $display("FAIL clear k=%0d got=%b exp=%b", k, {state, tick_en, cnt_clr, adj_mode, blink},
                 {es, et, es == S_CLR, es == S_ADJ, eb});
      end
      ps = es;
    end
    checks++;
    if (clr_pulses != 2) begin
      errors++;
      $display("FAIL clear_pulses got=%0d exp=2", clr_pulses);
    end
  endtask

  task automatic test_rst_abort();
    logic [1:0] es, ps;
    logic       eb, et;
    logic [8:0] obs;
    // rst during CLEAR
    apply_reset();
    for (int k = 1; k <= 7; k++) begin
      btn_clr = (k <= 6);
      @(posedge clk); #1;
    end
    checks++;
    if ({state, cnt_clr} !== {S_CLR, 1'b1}) begin
      errors++;
      $display("FAIL abort_pre got=%b exp=%b", {state, cnt_clr}, {S_CLR, 1'b1});
    end
    #2; rst = 1'b1; btn_clr = 1'b0; #1;
    obs = {state, tick_en, cnt_clr, adj_mode, blink, digit_idx, sel_field};
    checks++;
    if (obs !== {S_RUN, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL abort_clear_async got=%b exp=%b", obs,
               {S_RUN, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0});
    end
    @(negedge clk); rst = 1'b0;
    ps = S_RUN; eb = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      es = S_RUN;
      et = m_tick(ps, es, k);
      checks++;
      if ({state, tick_en, cnt_clr, blink} !== {es, et, 1'b0, eb}) begin
        errors++;
        $display("FAIL abort_clear_after k=%0d got=%b exp=%b", k,
                 {state, tick_en, cnt_clr, blink}, {es, et, 1'b0, eb});
      end
      ps = es;
    end
    // rst during a half-debounced pause press
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      btn_pause = 1'b1;
      @(posedge clk); #1;
    end
    #2; rst = 1'b1; btn_pause = 1'b0; #1;
    obs = {state, tick_en, cnt_clr, adj_mode, blink, digit_idx, sel_field};
    checks++;
    if (obs !== {S_RUN, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL abort_db_async got=%b exp=%b", obs,
               {S_RUN, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0});
    end
    @(negedge clk); rst = 1'b0;
    ps = S_RUN;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      es = S_RUN;
      et = m_tick(ps, es, k);
      checks++;
      if ({state, tick_en, cnt_clr} !== {es, et, 1'b0}) begin
        errors++;
        $display("FAIL abort_db_after k=%0d got=%b exp=%b", k,
                 {state, tick_en, cnt_clr}, {es, et, 1'b0});
      end
      ps = es;
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_pause();
    test_bounce();
    test_adjust();
    test_clear();
    test_rst_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
